// File: rtl/hmm_viterbi_decoder_if.sv
// rtl/hmm_viterbi_decoder_if.sv - observation/decoded-path stream bundle for the Viterbi decoder
interface hmm_viterbi_decoder_if #(
  parameter int DATA_PREC       = 16,
  parameter int HIDDEN_STATES   = 2,
  parameter int OBSERVED_STATES = 2
);
  localparam int SW = (HIDDEN_STATES > 1) ? $clog2(HIDDEN_STATES) : 1;
  localparam int OW = (OBSERVED_STATES > 1) ? $clog2(OBSERVED_STATES) : 1;

  logic                 in_valid;
  logic                 in_ready;
  logic [OW-1:0]        in_obs;
  logic                 out_valid;
  logic                 out_ready;
  logic [SW-1:0]        out_state;
  logic                 out_last;
  logic [DATA_PREC-1:0] out_prob;

  modport master (
    output in_valid, in_obs, out_ready,
    input  in_ready, out_valid, out_state, out_last, out_prob
  );

  modport slave (
    input  in_valid, in_obs, out_ready,
    output in_ready, out_valid, out_state, out_last, out_prob
  );
endinterface

// File: rtl/hmm_viterbi_decoder.sv
// rtl/hmm_viterbi_decoder.sv - sequential Viterbi decoder, one target state per cycle
// Path is traced back from the backpointer store and emitted newest-first.
module hmm_viterbi_decoder #(
  parameter int DATA_PREC       = 16,
  parameter int HIDDEN_STATES   = 2,
  parameter int OBSERVED_STATES = 2,
  parameter int OBSERVED_LEN    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_PREC-1:0] trans [HIDDEN_STATES][HIDDEN_STATES],
  input  logic [DATA_PREC-1:0] emm [HIDDEN_STATES][OBSERVED_STATES],
  input  logic [DATA_PREC-1:0] stationary_distribution [HIDDEN_STATES],
  hmm_viterbi_decoder_if.slave bus
);
  localparam int SW = (HIDDEN_STATES > 1) ? $clog2(HIDDEN_STATES) : 1;
  localparam int OW = (OBSERVED_STATES > 1) ? $clog2(OBSERVED_STATES) : 1;
  localparam int TW = (OBSERVED_LEN > 1) ? $clog2(OBSERVED_LEN) : 1;
  localparam logic [SW-1:0] J_LAST = SW'(HIDDEN_STATES - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OBSERVED_LEN - 1);

  typedef enum logic [1:0] {S_IN, S_CALC, S_ARGMAX, S_OUT} state_t;

  state_t               state_q, state_d;
  logic [TW-1:0]        t_q, t_d;
  logic [SW-1:0]        j_q, j_d;
  logic [OW-1:0]        obs_q, obs_d;
  logic [SW-1:0]        path_q, path_d;
  logic [DATA_PREC-1:0] prob_q, prob_d;
  logic [DATA_PREC-1:0] delta_prev_q [HIDDEN_STATES];
  logic [DATA_PREC-1:0] delta_prev_d [HIDDEN_STATES];
  logic [DATA_PREC-1:0] delta_cur_q [HIDDEN_STATES];
  logic [DATA_PREC-1:0] delta_cur_d [HIDDEN_STATES];
  logic [SW-1:0]        bp_q [OBSERVED_LEN][HIDDEN_STATES];
  logic [SW-1:0]        bp_d [OBSERVED_LEN][HIDDEN_STATES];

  logic [DATA_PREC-1:0] emit, cand, best_m, arg_v;
  logic [SW-1:0]        best_i, arg_i;

  function automatic logic [DATA_PREC-1:0] multiply(input logic [DATA_PREC-1:0] a,
                                                    input logic [DATA_PREC-1:0] b);
    logic [2*DATA_PREC-1:0] p;
    p = {{DATA_PREC{1'b0}}, a} * {{DATA_PREC{1'b0}}, b};
    return p[2*DATA_PREC-1:DATA_PREC];
  endfunction

  assign bus.in_ready  = (state_q == S_IN);
  assign bus.out_valid = (state_q == S_OUT);
  assign bus.out_last  = (state_q == S_OUT) && (t_q == '0);
  assign bus.out_state = path_q;
  assign bus.out_prob  = prob_q;

  always_comb begin
    state_d      = state_q;
    t_d          = t_q;
    j_d          = j_q;
    obs_d        = obs_q;
    path_d       = path_q;
    prob_d       = prob_q;
    delta_prev_d = delta_prev_q;
    delta_cur_d  = delta_cur_q;
    bp_d         = bp_q;

    emit = '0;
    if (int'(obs_q) < OBSERVED_STATES) emit = emm[j_q][obs_q];

    // Strict '>' keeps the lowest index on ties; all-zero resolves to 0.
    best_m = '0;
    best_i = '0;
    cand   = '0;
    for (int i = 0; i < HIDDEN_STATES; i++) begin
      cand = multiply(delta_prev_q[i], trans[i][j_q]);
      if (cand > best_m) begin
        best_m = cand;
        best_i = SW'(i);
      end
    end

    arg_v = '0;
    arg_i = '0;
    for (int k = 0; k < HIDDEN_STATES; k++) begin
      if (delta_cur_q[k] > arg_v) begin
        arg_v = delta_cur_q[k];
        arg_i = SW'(k);
      end
    end

    case (state_q)
      S_IN: begin
        if (bus.in_valid) begin
          obs_d   = bus.in_obs;
          j_d     = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (t_q == '0) begin
          delta_cur_d[j_q] = multiply(stationary_distribution[j_q], emit);
        end else begin
          delta_cur_d[j_q] = multiply(best_m, emit);
          bp_d[t_q][j_q]   = best_i;
        end
        if (j_q != J_LAST) begin
          j_d = j_q + SW'(1);
        end else if (t_q != T_LAST) begin
          delta_prev_d = delta_cur_d;
          t_d          = t_q + TW'(1);
          state_d      = S_IN;
        end else begin
          state_d = S_ARGMAX;
        end
      end
      S_ARGMAX: begin
        path_d  = arg_i;
        prob_d  = arg_v;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (bus.out_ready) begin
          if (t_q != '0) begin
            path_d = bp_q[t_q][path_q];
            t_d    = t_q - TW'(1);
          end else begin
            t_d     = '0;
            state_d = S_IN;
          end
        end
      end
      default: state_d = S_IN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IN;
      t_q     <= '0;
      j_q     <= '0;
      obs_q   <= '0;
      path_q  <= '0;
      prob_q  <= '0;
      for (int k = 0; k < HIDDEN_STATES; k++) begin
        delta_prev_q[k] <= '0;
        delta_cur_q[k]  <= '0;
      end
      for (int t = 0; t < OBSERVED_LEN; t++) begin
        for (int k = 0; k < HIDDEN_STATES; k++) begin
          bp_q[t][k] <= '0;
        end
      end
    end else begin
      state_q      <= state_d;
      t_q          <= t_d;
      j_q          <= j_d;
      obs_q        <= obs_d;
      path_q       <= path_d;
      prob_q       <= prob_d;
      delta_prev_q <= delta_prev_d;
      delta_cur_q  <= delta_cur_d;
      bp_q         <= bp_d;
    end
  end
endmodule

// File: tb/tb_hmm_viterbi_decoder.sv
// tb/tb_hmm_viterbi_decoder.sv - directed scoreboard bench for hmm_viterbi_decoder
module tb_hmm_viterbi_decoder;
  localparam int DP = 16;
  localparam int H  = 2;
  localparam int O  = 2;
  localparam int L  = 3;
  localparam int SW = 1;

  localparam logic [DP-1:0] P06 = 16'd39322;
  localparam logic [DP-1:0] P04 = 16'd26214;
  localparam logic [DP-1:0] P09 = 16'd58982;
  localparam logic [DP-1:0] P01 = 16'd6554;
  localparam logic [DP-1:0] P05 = 16'd32768;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DP-1:0] trans [H][H];
  logic [DP-1:0] emm [H][O];
  logic [DP-1:0] pi_v [H];

  hmm_viterbi_decoder_if #(.DATA_PREC(DP), .HIDDEN_STATES(H), .OBSERVED_STATES(O)) bus ();

  hmm_viterbi_decoder #(
    .DATA_PREC(DP), .HIDDEN_STATES(H), .OBSERVED_STATES(O), .OBSERVED_LEN(L)
  ) dut (
    .clk(clk),
    .rst(rst),
    .trans(trans),
    .emm(emm),
    .stationary_distribution(pi_v),
    .bus(bus)
  );

  typedef struct {
    logic [SW-1:0] state;
    logic          last;
    logic [DP-1:0] prob;
    int            tol;
  } beat_t;

  beat_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_in_ready"}, 32'(bus.in_ready), 1);
    chk({p, "_out_valid"}, 32'(bus.out_valid), 0);
    chk({p, "_out_last"}, 32'(bus.out_last), 0);
    chk({p, "_out_state"}, 32'(bus.out_state), 0);
    chk({p, "_out_prob"}, 32'(bus.out_prob), 0);
  endtask

  task automatic set_basic();
    trans[0][0] = P06; trans[0][1] = P04;
    trans[1][0] = P04; trans[1][1] = P06;
    emm[0][0] = P09; emm[0][1] = P01;
    emm[1][0] = P01; emm[1][1] = P09;
    pi_v[0] = P05; pi_v[1] = P05;
  endtask

  task automatic set_uniform();
    for (int a = 0; a < H; a++) begin
      pi_v[a] = P05;
      for (int b = 0; b < H; b++) trans[a][b] = P05;
      for (int b = 0; b < O; b++) emm[a][b] = P05;
    end
  endtask

  task automatic set_underflow();
    set_basic();
    emm[0][1] = '0;
    emm[1][1] = '0;
  endtask

  task automatic push3(input logic [SW-1:0] s0, input logic [SW-1:0] s1,
                       input logic [SW-1:0] s2, input logic [DP-1:0] prob, input int tol);
    sb.push_back('{state: s0, last: 1'b0, prob: prob, tol: tol});
    sb.push_back('{state: s1, last: 1'b0, prob: prob, tol: tol});
    sb.push_back('{state: s2, last: 1'b1, prob: prob, tol: tol});
  endtask

  task automatic push_basic();
    push3(1'b1, 1'b1, 1'b0, 16'h1666, 2);
  endtask

  // Called at a negedge; returns at the negedge just after the handshake edge.
  task automatic send_obs(input logic o);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_obs   = o;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", 0, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send3(input logic o0, input logic o1, input logic o2);
    send_obs(o0);
    send_obs(o1);
    send_obs(o2);
  endtask

  task automatic cmp_beat(input beat_t e);
    int d;
    chk("out_state", 32'(bus.out_state), 32'(e.state));
    chk("out_last", 32'(bus.out_last), 32'(e.last));
    d = int'(bus.out_prob) - int'(e.prob);
    if (d < 0) d = -d;
    checks++;
    assert (d <= e.tol) else begin
      errors++;
      $error("FAIL out_prob: observed %0h expected %0h tol %0d", bus.out_prob, e.prob, e.tol);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic drain(input bit stall);
    int n;
    bit first = 1'b1;
    logic [31:0] snap;
    while (sb.size() > 0) begin
      wait_valid(n);
      if (!bus.out_valid) begin
        chk("out_valid_timeout", 0, 1);
        sb.delete();
        return;
      end
      if (!stall && !first) chk("beat_gap", 32'(n), 0);
      first = 1'b0;
      if (stall) begin
        bus.out_ready = 1'b0;
        snap = 32'({bus.out_valid, bus.out_state, bus.out_last, bus.out_prob});
        repeat (5) begin
          @(negedge clk);
          chk("stall_stable", 32'({bus.out_valid, bus.out_state, bus.out_last, bus.out_prob}), snap);
        end
      end
      cmp_beat(sb.pop_front());
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
    end
    chk("in_ready_after_last", 32'(bus.in_ready), 1);
    chk("out_valid_after_last", 32'(bus.out_valid), 0);
  endtask

  initial begin
    int h[3];
    int k;
    int n;
    logic seq[3];

    bus.in_valid  = 1'b0;
    bus.in_obs    = '0;
    bus.out_ready = 1'b0;
    set_basic();

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset("rst_hold");
    rst = 1'b0;
    @(negedge clk);
    chk_reset("rst_after");

    push_basic();
    send3(1'b0, 1'b1, 1'b1);
    drain(1'b0);

    set_uniform();
    push3(1'b0, 1'b0, 1'b0, 16'd1024, 0);
    send3(1'b0, 1'b1, 1'b0);
    drain(1'b0);

    // in_valid held high across the whole sequence.
    set_basic();
    push_basic();
    seq[0] = 1'b0; seq[1] = 1'b1; seq[2] = 1'b1;
    k = 0;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_obs   = seq[0];
    while (k < 3 && n < 100) begin
      if (bus.in_ready) begin
        h[k] = cyc;
        k++;
        @(negedge clk);
        if (k < 3) bus.in_obs = seq[k];
      end else begin
        @(negedge clk);
      end
      n++;
    end
    bus.in_valid = 1'b0;
    chk("handshake_count", 32'(k), 3);
    if (k == 3) begin
      chk("in_ready_period_1", 32'(h[1] - h[0]), 3);
      chk("in_ready_period_2", 32'(h[2] - h[1]), 3);
      wait_valid(n);
      chk("out_valid_latency", 32'(cyc - h[2]), 4);
    end
    drain(1'b0);

    push_basic();
    send3(1'b0, 1'b1, 1'b1);
    drain(1'b1);

    // Reset during CALC of t=1.
    send_obs(1'b0);
    send_obs(1'b1);
    rst = 1'b1;
    #1;
    chk_reset("rst_calc");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset during OUT after the first beat.
    push_basic();
    send3(1'b0, 1'b1, 1'b1);
    wait_valid(n);
    chk("rst_out_valid_seen", 32'(bus.out_valid), 1);
    cmp_beat(sb.pop_front());
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset("rst_out");
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    push_basic();
    send3(1'b0, 1'b1, 1'b1);
    drain(1'b0);

    set_underflow();
    push3(1'b0, 1'b0, 1'b0, 16'd0, 0);
    send3(1'b1, 1'b1, 1'b1);
    drain(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
